// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the external memory bus arbiter: one-hot FSM states,
// master and memory-select encodings, and the round-robin winner helper.
package mcu_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SETUP  = 4'b0010,
    ST_ACCESS = 4'b0100,
    ST_DONE   = 4'b1000
  } bus_state_t;

  localparam logic MASTER_FETCH = 1'b0;
  localparam logic MASTER_DATA  = 1'b1;

  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;

  // A lone requester wins; on a tie the master that was not served last wins.
  function automatic logic pick_winner(input logic f_req, input logic d_req,
                                       input logic last_owner);
    logic winner;
    if (f_req && d_req) begin
      winner = ~last_owner;
    end else if (d_req) begin
      winner = MASTER_DATA;
    end else begin
      winner = MASTER_FETCH;
    end
    return winner;
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// 4-bit down counter that times the ACCESS phase: load a start value,
// decrement to zero, and flag when zero is reached.
module bus_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  // Load has priority so a new ACCESS phase always starts from a clean value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mcu_bus_arbiter.sv
// Arbitrates the external memory bus between the fetch and data ports and
// sequences every access through SETUP, ACCESS and DONE phases.
module mcu_bus_arbiter
  import mcu_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic              read_en,
  output logic              write_en,
  output logic              memory_select,
  output logic              owner,
  output logic              busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  bus_state_t state;
  bus_state_t next_state;

  logic grant;
  logic winner;
  logic is_read;
  logic legal_wr;
  logic rom_wr;
  logic wait_zero;
  logic last_access;

  assign grant       = (state == ST_IDLE) && (f_req || d_req);
  assign winner      = pick_winner(f_req, d_req, owner);
  assign last_access = (state == ST_ACCESS) && wait_zero;

  bus_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_SETUP),
    .dec      (state == ST_ACCESS),
    .load_val (WAIT_LOAD),
    .zero     (wait_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (f_req || d_req) next_state = ST_SETUP;
      ST_SETUP:  next_state = ST_ACCESS;
      ST_ACCESS: if (wait_zero) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Request fields are captured at grant; addr_bus and memory_select then hold
  // until the next grant, which gives the required hold behaviour in IDLE/DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner         <= MASTER_DATA;
      addr_bus      <= '0;
      memory_select <= SEL_RAM;
      data_out      <= '0;
      is_read       <= 1'b0;
      legal_wr      <= 1'b0;
      rom_wr        <= 1'b0;
    end else if (grant) begin
      owner <= winner;
      if (winner == MASTER_DATA) begin
        addr_bus      <= d_addr;
        memory_select <= d_sel;
        is_read       <= ~d_we;
        legal_wr      <= d_we && (d_sel == SEL_RAM);
        rom_wr        <= d_we && (d_sel == SEL_ROM);
        if (d_we && (d_sel == SEL_RAM)) begin
          data_out <= d_wdata;
        end
      end else begin
        addr_bus      <= f_addr;
        memory_select <= SEL_ROM;
        is_read       <= 1'b1;
        legal_wr      <= 1'b0;
        rom_wr        <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rdata <= '0;
      d_rdata <= '0;
    end else if (last_access && is_read) begin
      if (owner == MASTER_FETCH) begin
        f_rdata <= data_in;
      end else begin
        d_rdata <= data_in;
      end
    end
  end

  // Strobes decode straight from the state so an async reset clears them at once.
  always_comb begin
    read_en  = 1'b0;
    write_en = 1'b0;
    data_oe  = 1'b0;
    f_ack    = 1'b0;
    d_ack    = 1'b0;
    d_err    = 1'b0;
    busy     = (state != ST_IDLE);
    unique case (state)
      ST_SETUP: begin
        read_en = is_read;
        data_oe = legal_wr;
      end
      ST_ACCESS: begin
        read_en  = is_read;
        write_en = legal_wr;
        data_oe  = legal_wr;
      end
      ST_DONE: begin
        f_ack = (owner == MASTER_FETCH);
        d_ack = (owner == MASTER_DATA);
        d_err = (owner == MASTER_DATA) && rom_wr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// Randomised scoreboard bench for mcu_bus_arbiter (WAIT_CYCLES=2), plus
// WAIT_CYCLES=1 and 15 instances exercised with directed reads.
module tb_mcu_bus_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we, d_sel;
  logic [15:0] f_addr, d_addr;
  logic [7:0]  d_wdata;
  logic [7:0]  data_in = 8'h00;

  logic        f_ack, d_ack, d_err, data_oe, read_en, write_en, memory_select, owner, busy;
  logic [7:0]  f_rdata, d_rdata, data_out;
  logic [15:0] addr_bus;

  logic        s1_f_req, s1_d_req, s1_f_ack, s1_d_ack, s1_d_err, s1_data_oe, s1_read_en;
  logic        s1_write_en, s1_memory_select, s1_owner, s1_busy;
  logic [7:0]  s1_f_rdata, s1_d_rdata, s1_data_out;
  logic [15:0] s1_addr_bus;
  logic        s15_f_req, s15_d_req, s15_f_ack, s15_d_ack, s15_d_err, s15_data_oe, s15_read_en;
  logic        s15_write_en, s15_memory_select, s15_owner, s15_busy;
  logic [7:0]  s15_f_rdata, s15_d_rdata, s15_data_out;
  logic [15:0] s15_addr_bus;

  typedef struct {
    logic        master;
    int          ack_cyc;
    logic        is_read;
    logic [7:0]  rdata;
    logic        err;
    logic        legal_wr;
    logic [15:0] addr;
    logic        sel;
    logic [7:0]  wdata;
  } exp_t;

  typedef struct {
    logic       master;
    int         ack_cyc;
    logic [7:0] rdata;
  } sec_t;

  exp_t sb[$];
  sec_t sb1[$];
  sec_t sb15[$];

  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] seed;
  logic       last_grant;
  logic [7:0] f_hold, d_hold;
  int         rd_cnt, wr_cnt, oe_cnt;
  logic [7:0] wd_seen;
  exp_t       e_mon;
  sec_t       e1, e15;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcu_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .addr_bus(addr_bus), .data_out(data_out),
    .data_oe(data_oe), .data_in(data_in), .read_en(read_en), .write_en(write_en),
    .memory_select(memory_select), .owner(owner), .busy(busy)
  );

  mcu_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(reset), .f_req(s1_f_req), .f_addr(f_addr), .f_ack(s1_f_ack),
    .f_rdata(s1_f_rdata), .d_req(s1_d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(s1_d_ack), .d_rdata(s1_d_rdata), .d_err(s1_d_err),
    .addr_bus(s1_addr_bus), .data_out(s1_data_out), .data_oe(s1_data_oe), .data_in(data_in),
    .read_en(s1_read_en), .write_en(s1_write_en), .memory_select(s1_memory_select),
    .owner(s1_owner), .busy(s1_busy)
  );

  mcu_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(15)) u_dut_w15 (
    .clk(clk), .reset(reset), .f_req(s15_f_req), .f_addr(f_addr), .f_ack(s15_f_ack),
    .f_rdata(s15_f_rdata), .d_req(s15_d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(s15_d_ack), .d_rdata(s15_d_rdata), .d_err(s15_d_err),
    .addr_bus(s15_addr_bus), .data_out(s15_data_out), .data_oe(s15_data_oe), .data_in(data_in),
    .read_en(s15_read_en), .write_en(s15_write_en), .memory_select(s15_memory_select),
    .owner(s15_owner), .busy(s15_busy)
  );

  // Read data on the bus is a known function of the cycle number.
  function automatic logic [7:0] pat(input int n);
    return 8'(n * 29) ^ seed;
  endfunction

  always @(negedge clk) data_in = pat(cyc);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_strobes"}, {read_en, write_en, data_oe}, 0);
    checkOutput({tag, "_acks"}, {f_ack, d_ack, d_err}, 0);
    checkOutput({tag, "_addr_bus"}, addr_bus, 0);
    checkOutput({tag, "_data_out"}, data_out, 0);
    checkOutput({tag, "_f_rdata"}, f_rdata, 0);
    checkOutput({tag, "_d_rdata"}, d_rdata, 0);
    checkOutput({tag, "_memory_select"}, memory_select, 1);
    checkOutput({tag, "_owner"}, owner, 1);
  endtask

  // Expected outcome of one granted transaction whose IDLE cycle is c.
  task automatic pushItem(input logic m, input int c, input logic we, input logic sel,
                          input logic [15:0] fa, input logic [15:0] da, input logic [7:0] wd);
    exp_t e;
    e.master   = m;
    e.ack_cyc  = c + W + 2;
    e.is_read  = m ? ~we : 1'b1;
    e.rdata    = pat(c + W + 1);
    e.err      = m & we & ~sel;
    e.legal_wr = m & we & sel;
    e.addr     = m ? da : fa;
    e.sel      = m ? sel : 1'b0;
    e.wdata    = wd;
    sb.push_back(e);
  endtask

  // mode 0 = fetch only, 1 = data only, 2 = both at once. Called at a negedge in IDLE.
  task automatic applyStimulus(input int mode, input logic we, input logic sel,
                               input logic [15:0] fa, input logic [15:0] da, input logic [7:0] wd);
    logic win;
    int   c0;
    f_addr  = fa;
    d_addr  = da;
    d_we    = we;
    d_sel   = sel;
    d_wdata = wd;
    f_req   = (mode != 1);
    d_req   = (mode != 0);
    c0      = cyc;
    win     = (mode == 2) ? ~last_grant : (mode == 1);
    pushItem(win, c0, we, sel, fa, da, wd);
    if (mode == 2) begin
      pushItem(~win, c0 + W + 3, we, sel, fa, da, wd);
      last_grant = ~win;
    end else begin
      last_grant = win;
    end
    for (int i = 0; i < 4 * W + 24 && (f_req || d_req); i++) begin
      @(negedge clk);
      if (f_ack) f_req = 1'b0;
      if (d_ack) d_req = 1'b0;
    end
    checkOutput("req_timeout", {f_req, d_req}, 0);
  endtask

  task automatic randomRound();
    applyStimulus($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 8'($urandom));
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
      oe_cnt = 0;
    end else begin
      rd_cnt += int'(read_en);
      wr_cnt += int'(write_en);
      oe_cnt += int'(data_oe);
      if (write_en) wd_seen = data_out;
      if (read_en && write_en) failNow("read_write_overlap");
      if (f_ack || d_ack) begin
        if (sb.size() == 0) begin
          failNow("unexpected_ack");
        end else begin
          e_mon = sb.pop_front();
          if (e_mon.is_read) begin
            if (e_mon.master) d_hold = e_mon.rdata;
            else f_hold = e_mon.rdata;
          end
          checkOutput("ack_which", {f_ack, d_ack}, e_mon.master ? 2'b01 : 2'b10);
          checkOutput("ack_cycle", cyc, e_mon.ack_cyc);
          checkOutput("owner", owner, e_mon.master);
          checkOutput("addr_bus", addr_bus, e_mon.addr);
          checkOutput("memory_select", memory_select, e_mon.sel);
          checkOutput("d_err", d_err, e_mon.err);
          checkOutput("done_strobes", {read_en, write_en, data_oe}, 0);
          checkOutput("busy_done", busy, 1);
          checkOutput("f_rdata", f_rdata, f_hold);
          checkOutput("d_rdata", d_rdata, d_hold);
          checkOutput("read_en_cycles", rd_cnt, e_mon.is_read ? W + 1 : 0);
          checkOutput("write_en_cycles", wr_cnt, e_mon.legal_wr ? W : 0);
          checkOutput("data_oe_cycles", oe_cnt, e_mon.legal_wr ? W + 1 : 0);
          if (e_mon.legal_wr) checkOutput("data_out", wd_seen, e_mon.wdata);
        end
        rd_cnt = 0;
        wr_cnt = 0;
        oe_cnt = 0;
      end else begin
        if (d_err) failNow("d_err_without_ack");
        if (f_rdata !== f_hold) checkOutput("f_rdata_hold", f_rdata, f_hold);
        if (d_rdata !== d_hold) checkOutput("d_rdata_hold", d_rdata, d_hold);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (s1_f_ack || s1_d_ack)) begin
      if (sb1.size() == 0) begin
        failNow("w1_unexpected_ack");
      end else begin
        e1 = sb1.pop_front();
        checkOutput("w1_ack_which", {s1_f_ack, s1_d_ack}, e1.master ? 2'b01 : 2'b10);
        checkOutput("w1_ack_cycle", cyc, e1.ack_cyc);
        checkOutput("w1_rdata", e1.master ? s1_d_rdata : s1_f_rdata, e1.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (s15_f_ack || s15_d_ack)) begin
      if (sb15.size() == 0) begin
        failNow("w15_unexpected_ack");
      end else begin
        e15 = sb15.pop_front();
        checkOutput("w15_ack_which", {s15_f_ack, s15_d_ack}, e15.master ? 2'b01 : 2'b10);
        checkOutput("w15_ack_cycle", cyc, e15.ack_cyc);
        checkOutput("w15_rdata", e15.master ? s15_d_rdata : s15_f_rdata, e15.rdata);
      end
    end
  end

  // Same request issued to both short- and long-wait instances at once.
  task automatic secondaryRead(input logic m);
    int   c0;
    sec_t s;
    f_addr = 16'h0200;
    d_addr = 16'h0044;
    d_we   = 1'b0;
    d_sel  = 1'b1;
    c0     = cyc;
    s.master = m;
    s.ack_cyc = c0 + 3;
    s.rdata = pat(c0 + 2);
    sb1.push_back(s);
    s.ack_cyc = c0 + 17;
    s.rdata = pat(c0 + 16);
    sb15.push_back(s);
    s1_f_req  = ~m;
    s15_f_req = ~m;
    s1_d_req  = m;
    s15_d_req = m;
    for (int i = 0; i < 40 && (s1_f_req || s1_d_req || s15_f_req || s15_d_req); i++) begin
      @(negedge clk);
      if (s1_f_ack) s1_f_req = 1'b0;
      if (s1_d_ack) s1_d_req = 1'b0;
      if (s15_f_ack) s15_f_req = 1'b0;
      if (s15_d_ack) s15_d_req = 1'b0;
    end
    checkOutput("secondary_timeout", {s1_f_req, s1_d_req, s15_f_req, s15_d_req}, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    seed = 8'($urandom);
    reset = 1'b1;
    {f_req, d_req, d_we, d_sel} = '0;
    {s1_f_req, s1_d_req, s15_f_req, s15_d_req} = '0;
    f_addr = '0;
    d_addr = '0;
    d_wdata = '0;
    last_grant = 1'b1;
    f_hold = '0;
    d_hold = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(2, 1'b0, 1'b1, 16'h0100, 16'h0020, 8'h00);
    repeat (2) @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 16'h0100, 16'h0000, 8'h00);
    repeat (1) @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 16'h0000, 16'h0030, 8'h5C);
    repeat (1) @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, 16'h0000, 16'h0031, 8'hE7);
    repeat (1) @(negedge clk);
    for (int r = 0; r < 40; r++) randomRound();

    secondaryRead(1'b0);
    secondaryRead(1'b1);
    checkOutput("secondary_sb_empty", sb1.size() + sb15.size(), 0);

    f_addr = 16'h0155;
    f_req  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_access_read_en", read_en, 1);
    reset = 1'b1;
    f_req = 1'b0;
    sb.delete();
    f_hold = '0;
    d_hold = '0;
    last_grant = 1'b1;
    #1;
    checkResetValues("mid_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 16'h0101, 16'h0000, 8'h00);
    repeat (1) @(negedge clk);
    for (int r = 0; r < 5; r++) randomRound();

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
